// File: rtl/tx_frame_sequencer_if.sv
// Request, payload byte stream and serial bit stream of the TX frame sequencer.
// The sequencer takes the slave side; the frame source and bit sink take the master side.
interface tx_frame_sequencer_if;
  logic        iStart;
  logic [3:0]  iRate;
  logic [11:0] iLength;
  logic [7:0]  iByte;
  logic        iByteValid;
  logic        oByteReady;
  logic        oData;
  logic        oValid;
  logic        iReady;
  logic [2:0]  oSeg;
  logic        oScrEN;
  logic [3:0]  oRate;
  logic        oRateLoad;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  modport master (
    output iStart, iRate, iLength, iByte, iByteValid, iReady,
    input  oByteReady, oData, oValid, oSeg, oScrEN, oRate, oRateLoad, oBusy, oDone, oErr
  );

  modport slave (
    input  iStart, iRate, iLength, iByte, iByteValid, iReady,
    output oByteReady, oData, oValid, oSeg, oScrEN, oRate, oRateLoad, oBusy, oDone, oErr
  );
endinterface

// File: rtl/tx_frame_sequencer.sv
// 802.11a transmit frame sequencer: serialises preamble, SIGNAL, SERVICE, PSDU, TAIL and PAD
// and strobes segment/scramble/rate-load controls for the downstream coding chain.
module tx_frame_sequencer #(
  parameter logic [11:0] HEADER  = 12'hFFF,
  parameter int          PRE_LEN = 12
) (
  input  logic            iClk,
  input  logic            iRst,
  tx_frame_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SIG, S_RLOAD, S_SERV, S_DATA, S_TAIL, S_PAD, S_DONE
  } state_t;

  localparam logic [14:0] PRE_LAST = 15'(PRE_LEN - 1);

  state_t      state_q, state_d;
  logic [3:0]  rate_q;
  logic [11:0] len_q;
  logic [14:0] bit_cnt_q;
  logic [7:0]  sym_q;
  logic [11:0] accepted_q;
  logic [7:0]  hold_q, shift_q;
  logic        hold_full_q, shift_full_q;
  logic [2:0]  bit_in_byte_q;
  logic        err_q;

  logic        valid, xfer, scr, data_bit;
  logic [2:0]  seg;
  logic        req_ok, rate_ok, sym_wrap, byte_ready, byte_take, load_shift, start_ok;
  logic [7:0]  sym_last;
  logic [14:0] data_last;
  logic [3:0]  pre_idx;
  logic [23:0] sig_word;

  // Only the eight legal RATE codes are accepted; they are exactly the codes with R4=1.
  always_comb begin
    rate_ok = 1'b0;
    case (bus.iRate)
      4'b1101, 4'b1111, 4'b0101, 4'b0111,
      4'b1001, 4'b1011, 4'b0001, 4'b0011: rate_ok = 1'b1;
      default: rate_ok = 1'b0;
    endcase
  end

  always_comb begin
    sym_last = 8'd23;
    case (rate_q)
      4'b1101: sym_last = 8'd23;
      4'b1111: sym_last = 8'd35;
      4'b0101: sym_last = 8'd47;
      4'b0111: sym_last = 8'd71;
      4'b1001: sym_last = 8'd95;
      4'b1011: sym_last = 8'd143;
      4'b0001: sym_last = 8'd191;
      4'b0011: sym_last = 8'd215;
      default: sym_last = 8'd23;
    endcase
  end

  assign req_ok    = rate_ok && (bus.iLength != 12'd0);
  assign start_ok  = (state_q == S_IDLE) && bus.iStart && req_ok;
  assign sym_wrap  = (sym_q == sym_last);
  assign data_last = {len_q, 3'b000} - 15'd1;
  assign pre_idx   = 4'(PRE_LEN - 1) - bit_cnt_q[3:0];
  assign sig_word  = {6'b0, ^{len_q, rate_q}, len_q, 1'b0,
                      rate_q[0], rate_q[1], rate_q[2], rate_q[3]};

  // Output decode first, then next state, so the transfer strobe is settled before use.
  always_comb begin
    state_d  = state_q;
    valid    = 1'b0;
    seg      = 3'd0;
    scr      = 1'b0;
    data_bit = 1'b0;
    case (state_q)
      S_PRE:   begin valid = 1'b1; seg = 3'd1; data_bit = HEADER[pre_idx]; end
      S_SIG:   begin valid = 1'b1; seg = 3'd2; data_bit = sig_word[bit_cnt_q[4:0]]; end
      S_RLOAD: seg = 3'd3;
      S_SERV:  begin valid = 1'b1; seg = 3'd3; scr = 1'b1; end
      S_DATA:  begin valid = shift_full_q; seg = 3'd4; scr = 1'b1; data_bit = shift_q[0]; end
      S_TAIL:  begin valid = 1'b1; seg = 3'd5; end
      S_PAD:   begin valid = 1'b1; seg = 3'd6; scr = 1'b1; end
      default: ;
    endcase
    xfer = valid && bus.iReady;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_PRE;
      S_PRE:   if (xfer && bit_cnt_q == PRE_LAST) state_d = S_SIG;
      S_SIG:   if (xfer && bit_cnt_q == 15'd23) state_d = S_RLOAD;
      S_RLOAD: state_d = S_SERV;
      S_SERV:  if (xfer && bit_cnt_q == 15'd15) state_d = S_DATA;
      S_DATA:  if (xfer && bit_cnt_q == data_last) state_d = S_TAIL;
      S_TAIL:  if (xfer && bit_cnt_q == 15'd5) state_d = sym_wrap ? S_DONE : S_PAD;
      S_PAD:   if (xfer && sym_wrap) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  assign byte_ready = ((state_q == S_RLOAD) || (state_q == S_SERV) || (state_q == S_DATA))
                      && !hold_full_q && (accepted_q < len_q);
  assign byte_take  = byte_ready && bus.iByteValid;
  assign load_shift = hold_full_q &&
                      (!shift_full_q || (xfer && state_q == S_DATA && bit_in_byte_q == 3'd7));

  // Counters advance only on a transfer; the bit counter restarts at every segment change.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rate_q        <= '0;
      len_q         <= '0;
      bit_cnt_q     <= '0;
      sym_q         <= '0;
      accepted_q    <= '0;
      hold_q        <= '0;
      shift_q       <= '0;
      hold_full_q   <= 1'b0;
      shift_full_q  <= 1'b0;
      bit_in_byte_q <= '0;
      err_q         <= 1'b0;
    end else begin
      err_q <= (state_q == S_IDLE) && bus.iStart && !req_ok;
      if (start_ok) begin
        rate_q        <= bus.iRate;
        len_q         <= bus.iLength;
        bit_cnt_q     <= '0;
        sym_q         <= '0;
        accepted_q    <= '0;
        hold_full_q   <= 1'b0;
        shift_full_q  <= 1'b0;
        bit_in_byte_q <= '0;
      end else begin
        if (state_d != state_q) bit_cnt_q <= '0;
        else if (xfer)          bit_cnt_q <= bit_cnt_q + 15'd1;

        if (state_q == S_RLOAD)
          sym_q <= '0;
        else if (xfer && (state_q == S_SERV || state_q == S_DATA ||
                          state_q == S_TAIL || state_q == S_PAD))
          sym_q <= sym_wrap ? 8'd0 : sym_q + 8'd1;

        if (byte_take) begin
          hold_q      <= bus.iByte;
          hold_full_q <= 1'b1;
          accepted_q  <= accepted_q + 12'd1;
        end

        if (load_shift) begin
          shift_q       <= hold_q;
          shift_full_q  <= 1'b1;
          hold_full_q   <= 1'b0;
          bit_in_byte_q <= '0;
        end else if (xfer && state_q == S_DATA) begin
          shift_q       <= shift_q >> 1;
          bit_in_byte_q <= bit_in_byte_q + 3'd1;
          if (bit_in_byte_q == 3'd7) shift_full_q <= 1'b0;
        end
      end
    end
  end

  assign bus.oByteReady = byte_ready;
  assign bus.oData      = data_bit;
  assign bus.oValid     = valid;
  assign bus.oSeg       = seg;
  assign bus.oScrEN     = scr;
  assign bus.oRate      = rate_q;
  assign bus.oRateLoad  = (state_q == S_RLOAD);
  assign bus.oBusy      = (state_q != S_IDLE);
  assign bus.oDone      = (state_q == S_DONE);
  assign bus.oErr       = err_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer: each frame's expected bit/segment/scramble stream
// is queued from a reference model when requested and popped on every bit transfer.
module tb_tx_frame_sequencer;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [4:0] exp_q[$];
  logic [7:0] payload[0:4096];

  tx_frame_sequencer_if bus();

  tx_frame_sequencer dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_outputs();
    return {bus.oByteReady, bus.oData, bus.oValid, bus.oSeg, bus.oScrEN,
            bus.oRate, bus.oRateLoad, bus.oBusy, bus.oDone, bus.oErr};
  endfunction

  function automatic int ndbps(input logic [3:0] rate);
    case (rate)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      default: return 216;
    endcase
  endfunction

  // Each entry is {bit, segment, scramble enable}.
  function automatic void build_expected(input logic [3:0] rate, input int len);
    logic [11:0] hdr;
    logic [11:0] len_v;
    logic [23:0] sb;
    logic [7:0]  b;
    logic        par;
    int          total, pad;
    hdr   = 12'hFFF;
    len_v = len[11:0];
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back({hdr[11 - i], 3'd1, 1'b0});
    sb = '0;
    sb[0] = rate[3]; sb[1] = rate[2]; sb[2] = rate[1]; sb[3] = rate[0];
    for (int i = 0; i < 12; i++) sb[5 + i] = len_v[i];
    par = 1'b0;
    for (int i = 0; i < 17; i++) par = par ^ sb[i];
    sb[17] = par;
    for (int i = 0; i < 24; i++) exp_q.push_back({sb[i], 3'd2, 1'b0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 3'd3, 1'b1});
    for (int k = 0; k < len; k++) begin
      b = payload[k];
      for (int i = 0; i < 8; i++) exp_q.push_back({b[i], 3'd4, 1'b1});
    end
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 3'd5, 1'b0});
    total = 16 + 8 * len + 6;
    pad   = (ndbps(rate) - (total % ndbps(rate))) % ndbps(rate);
    for (int i = 0; i < pad; i++) exp_q.push_back({1'b0, 3'd6, 1'b1});
  endfunction

  // Runs one frame request; abort_at >= 0 pulses reset when that many bits have transferred.
  task automatic apply_stimulus(input logic [3:0] rate, input int len, input bit gaps,
                                input bit hold_start, input int abort_at, input string name);
    int acc, popped, dones, cyc;
    bit finished;
    logic [4:0] e;
    build_expected(rate, len);
    acc = 0; popped = 0; dones = 0; finished = 1'b0;
    for (cyc = 0; cyc < 20000 && !finished; cyc++) begin
      @(posedge iClk); #1;
      bus.iStart     = (cyc == 0) || hold_start;
      bus.iRate      = rate;
      bus.iLength    = len[11:0];
      bus.iByte      = payload[acc];
      bus.iByteValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.iReady     = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge iClk);
      if (abort_at >= 0 && popped == abort_at && bus.oValid) begin
        check_output({name, "_abort_seg"}, 32'(bus.oSeg), 32'd2);
        iRst = 1'b1;
        #1;
        check_output({name, "_reset_outputs"}, 32'(all_outputs()), 32'd0);
        @(posedge iClk); #1;
        bus.iStart = 1'b0; bus.iByteValid = 1'b0;
        iRst = 1'b0;
        exp_q.delete();
        return;
      end
      if (bus.oValid && bus.iReady) begin
        if (exp_q.size() == 0) check_output({name, "_extra_bit"}, 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check_output({name, "_bit"}, 32'({bus.oData, bus.oSeg, bus.oScrEN}), 32'(e));
        end
        popped++;
      end
      if (bus.oByteReady && bus.iByteValid) acc++;
      if (bus.oRateLoad) check_output({name, "_rate_load"}, 32'(bus.oRate), 32'(rate));
      if (bus.oDone) begin dones++; finished = 1'b1; end
    end
    check_output({name, "_done_once"}, 32'(dones), 32'd1);
    check_output({name, "_bytes_accepted"}, 32'(acc), 32'(len));
    check_output({name, "_bits_left"}, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge iClk); #1;
      bus.iStart = 1'b0; bus.iByteValid = 1'b1; bus.iReady = 1'b1;
      @(negedge iClk);
      check_output({name, "_idle_after"}, 32'({bus.oBusy, bus.oValid, bus.oByteReady}), 32'd0);
    end
  endtask

  task automatic reject_request(input logic [3:0] rate, input logic [11:0] len, input string name);
    @(posedge iClk); #1;
    bus.iStart = 1'b1; bus.iRate = rate; bus.iLength = len;
    @(posedge iClk); #1;
    bus.iStart = 1'b0;
    @(negedge iClk);
    check_output({name, "_err_pulse"}, 32'(bus.oErr), 32'd1);
    check_output({name, "_stay_idle"}, 32'({bus.oBusy, bus.oValid, bus.oByteReady}), 32'd0);
    @(posedge iClk); #1;
    @(negedge iClk);
    check_output({name, "_err_clear"}, 32'({bus.oErr, bus.oBusy, bus.oValid}), 32'd0);
  endtask

  initial begin
    bus.iStart = 1'b0; bus.iRate = '0; bus.iLength = '0;
    bus.iByte = '0; bus.iByteValid = 1'b0; bus.iReady = 1'b1;
    for (int i = 0; i <= 4096; i++) payload[i] = 8'h00;

    @(negedge iClk);
    check_output("reset_outputs", 32'(all_outputs()), 32'd0);
    @(posedge iClk); #1;
    iRst = 1'b0;

    payload[0] = 8'hA5;
    apply_stimulus(4'b1101, 1, 1'b0, 1'b0, -1, "r6_len1");

    for (int i = 0; i < 100; i++) payload[i] = 8'(i);
    apply_stimulus(4'b0011, 100, 1'b0, 1'b0, -1, "r54_len100");

    reject_request(4'b0000, 12'd5, "bad_rate");
    reject_request(4'b1101, 12'd0, "zero_len");

    for (int i = 0; i < 12; i++) payload[i] = 8'($urandom_range(0, 255));
    apply_stimulus(4'b1001, 10, 1'b0, 1'b0, -1, "r24_nogap");
    apply_stimulus(4'b1001, 10, 1'b1, 1'b0, -1, "r24_gaps");

    payload[0] = 8'h3C;
    apply_stimulus(4'b1101, 1, 1'b0, 1'b0, 19, "abort");
    apply_stimulus(4'b1101, 1, 1'b0, 1'b0, -1, "after_abort");

    for (int i = 0; i < 3; i++) payload[i] = 8'hC1 + 8'(i);
    apply_stimulus(4'b0101, 3, 1'b0, 1'b1, -1, "start_held");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
